// File: rtl/synapse_dendrite_if.sv
// synapse_dendrite_if: Vm memory port between the dendrite stage (master) and the external Vm RAM (slave).
interface synapse_dendrite_if #(
    parameter int NNW = 12,
    parameter int VW  = 16
);
    logic           sd_vm_re;
    logic [NNW-1:0] sd_vm_raddr;
    logic [VW-1:0]  vm_sd_rdata;
    logic           sd_vm_we;
    logic [NNW-1:0] sd_vm_waddr;
    logic [VW-1:0]  sd_vm_wdata;
    modport master (
        output sd_vm_re, sd_vm_raddr, sd_vm_we, sd_vm_waddr, sd_vm_wdata,
        input  vm_sd_rdata
    );
    modport slave (
        input  sd_vm_re, sd_vm_raddr, sd_vm_we, sd_vm_waddr, sd_vm_wdata,
        output vm_sd_rdata
    );
endinterface

// File: rtl/synapse_dendrite.sv
// synapse_dendrite: 3-stage weight + Vm saturating accumulate with read-after-write forwarding.
module synapse_dendrite #(
    parameter int NNW = 12,
    parameter int WD  = 6,
    parameter int WW  = 8,
    parameter int VW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axon_sd_vld,
    input  logic [NNW-1:0]        axon_sd_vm_addr,
    input  logic [WD-1:0]         axon_sd_wgt_addr,
    input  logic                  wgt_we,
    input  logic [WD-1:0]         wgt_waddr,
    input  logic [WW-1:0]         wgt_wdata,
    synapse_dendrite_if.master    vm,
    output logic                  sd_busy
);
    localparam logic [VW-1:0] VMAX = {1'b0, {(VW-1){1'b1}}};
    localparam logic [VW-1:0] VMIN = {1'b1, {(VW-1){1'b0}}};

    logic [WW-1:0]  wgt_mem [2**WD];
    logic [WW-1:0]  wgt_q;
    logic           s1_vld;
    logic [NNW-1:0] s1_vm_addr;
    logic           lw_vld;
    logic [NNW-1:0] lw_addr;
    logic [VW-1:0]  lw_data;
    logic [VW-1:0]  vm_op;
    logic [VW:0]    sum;
    logic [VW-1:0]  sat;

    assign vm.sd_vm_re    = axon_sd_vld & rst_n;
    assign vm.sd_vm_raddr = axon_sd_vm_addr;
    assign sd_busy        = (axon_sd_vld & rst_n) | s1_vld | vm.sd_vm_we;

    // Read-before-write: a same-cycle config write is seen only by later requests
    always_ff @(posedge clk) begin
        if (wgt_we)
            wgt_mem[wgt_waddr] <= wgt_wdata;
        wgt_q <= wgt_mem[axon_sd_wgt_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_vm_addr <= '0;
        end else begin
            s1_vld     <= axon_sd_vld;
            s1_vm_addr <= axon_sd_vm_addr;
        end
    end

    // The external RAM returns stale data for the two most recent writes, so those win
    always_comb begin
        vm_op = (vm.sd_vm_we && vm.sd_vm_waddr == s1_vm_addr) ? vm.sd_vm_wdata :
                (lw_vld && lw_addr == s1_vm_addr)             ? lw_data :
                                                                vm.vm_sd_rdata;
        sum   = {vm_op[VW-1], vm_op} + {{(VW+1-WW){wgt_q[WW-1]}}, wgt_q};
        sat   = (sum[VW] == sum[VW-1]) ? sum[VW-1:0] : (sum[VW] ? VMIN : VMAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vm.sd_vm_we    <= 1'b0;
            vm.sd_vm_waddr <= '0;
            vm.sd_vm_wdata <= '0;
        end else begin
            vm.sd_vm_we <= s1_vld;
            if (s1_vld) begin
                vm.sd_vm_waddr <= s1_vm_addr;
                vm.sd_vm_wdata <= sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lw_vld  <= 1'b0;
            lw_addr <= '0;
            lw_data <= '0;
        end else begin
            lw_vld  <= vm.sd_vm_we;
            lw_addr <= vm.sd_vm_waddr;
            lw_data <= vm.sd_vm_wdata;
        end
    end
endmodule
